// File: rtl/round_raw_fn_pipe.sv
// Two-stage rounder/packer for normalized raw floats.
// Stage 1 denormalizes tiny operands into the subnormal range, folding every
// shifted-out bit into sticky. Stage 2 rounds, handles overflow and specials,
// then packs the IEEE-754 encoding and the exception flags.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    upstream handshake
//   in_is_nan/inf/zero   special-case flags (priority NaN > inf > zero)
//   in_sign, in_sexp     sign, signed unbiased exponent
//   in_sig               {significand with hidden bit, round, sticky}
//   in_invalid, in_rm    forwarded invalid flag, rounding mode
//   out_valid/out_ready  downstream handshake
//   out_bits, out_flags  {sign, exp, frac}, {NV, DZ, OF, UF, NX}
module round_raw_fn_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned SIG_W = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_is_nan,
  input  logic                   in_is_inf,
  input  logic                   in_is_zero,
  input  logic                   in_sign,
  input  logic [EXP_W+1:0]       in_sexp,
  input  logic [SIG_W+1:0]       in_sig,
  input  logic                   in_invalid,
  input  logic [2:0]             in_rm,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+SIG_W-1:0] out_bits,
  output logic [4:0]             out_flags
);

  localparam int unsigned EW  = EXP_W + 2;
  localparam int unsigned SW  = SIG_W + 1;  // {sig, round} width
  localparam int unsigned ShW = $clog2(SW + 1);
  localparam int unsigned FW  = SIG_W - 1;
  localparam logic [EW-1:0]  Bias    = EW'((2 ** (EXP_W - 1)) - 1);
  localparam logic [EW:0]    ExpOvf  = (EW + 1)'((2 ** EXP_W) - 1);

  localparam logic [2:0] RmRtz = 3'd1;
  localparam logic [2:0] RmRdn = 3'd2;
  localparam logic [2:0] RmRup = 3'd3;
  localparam logic [2:0] RmRmm = 3'd4;

  // Flow control
  logic s1_valid_q, s2_valid_q;
  logic adv2;

  assign adv2      = ~s2_valid_q | out_ready;
  assign in_ready  = ~s1_valid_q | adv2;
  assign out_valid = s2_valid_q;

  // Stage 1: denormalize
  logic [EW-1:0]     e_pre;
  logic [EW-1:0]     sh_full;
  logic [ShW-1:0]    sh;
  logic [2*SW-1:0]   shifted;
  logic [EW-1:0]     s1_exp_d;
  logic [SIG_W-1:0]  s1_sig_d;
  logic              s1_r_d, s1_s_d, s1_tiny_d;

  always_comb begin
    e_pre     = in_sexp + Bias;
    s1_tiny_d = e_pre[EW-1] | (e_pre == '0);
    sh_full   = EW'(1) - e_pre;
    // Any shift past the whole {sig, r} field leaves only sticky behind.
    sh        = (sh_full > EW'(SW)) ? ShW'(SW) : sh_full[ShW-1:0];
    shifted   = {in_sig[SIG_W+1:1], {SW{1'b0}}} >> sh;
    if (s1_tiny_d) begin
      s1_exp_d = '0;
      s1_sig_d = shifted[2*SW-1 -: SIG_W];
      s1_r_d   = shifted[SW];
      s1_s_d   = in_sig[0] | (|shifted[SW-1:0]);
    end else begin
      s1_exp_d = e_pre;
      s1_sig_d = in_sig[SIG_W+1:2];
      s1_r_d   = in_sig[1];
      s1_s_d   = in_sig[0];
    end
  end

  logic              s1_sign_q, s1_r_q, s1_s_q, s1_tiny_q;
  logic              s1_nan_q, s1_inf_q, s1_zero_q, s1_inv_q;
  logic [EW-1:0]     s1_exp_q;
  logic [SIG_W-1:0]  s1_sig_q;
  logic [2:0]        s1_rm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_sig_q   <= '0;
      s1_r_q     <= 1'b0;
      s1_s_q     <= 1'b0;
      s1_tiny_q  <= 1'b0;
      s1_rm_q    <= '0;
      s1_nan_q   <= 1'b0;
      s1_inf_q   <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_inv_q   <= 1'b0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_sign_q <= in_sign;
        s1_exp_q  <= s1_exp_d;
        s1_sig_q  <= s1_sig_d;
        s1_r_q    <= s1_r_d;
        s1_s_q    <= s1_s_d;
        s1_tiny_q <= s1_tiny_d;
        s1_rm_q   <= in_rm;
        s1_nan_q  <= in_is_nan;
        s1_inf_q  <= in_is_inf;
        s1_zero_q <= in_is_zero;
        s1_inv_q  <= in_invalid;
      end
    end
  end

  // Stage 2: round and pack
  logic                   inc, inexact, ovf, ovf_to_inf;
  logic [SIG_W:0]         sum;
  logic [EW:0]            exp_fin;
  logic [FW-1:0]          frac;
  logic [EXP_W+SIG_W-1:0] res_bits;
  logic [4:0]             res_flags;

  always_comb begin
    case (s1_rm_q)
      RmRtz:   inc = 1'b0;
      RmRdn:   inc = s1_sign_q & (s1_r_q | s1_s_q);
      RmRup:   inc = ~s1_sign_q & (s1_r_q | s1_s_q);
      RmRmm:   inc = s1_r_q;
      default: inc = s1_r_q & (s1_s_q | s1_sig_q[0]);
    endcase
    inexact = s1_r_q | s1_s_q;
    sum     = {1'b0, s1_sig_q} + (SIG_W + 1)'(inc);
    exp_fin = {1'b0, s1_exp_q};
    frac    = sum[FW-1:0];
    if (s1_exp_q != '0) begin
      // Carry out of the significand: renormalize by one position.
      if (sum[SIG_W]) begin
        exp_fin = exp_fin + (EW + 1)'(1);
        frac    = sum[FW:1];
      end
    end else if (sum[SIG_W-1]) begin
      // Subnormal rounded up into the hidden bit becomes the smallest normal.
      exp_fin = (EW + 1)'(1);
    end
    ovf = (exp_fin >= ExpOvf);
    case (s1_rm_q)
      RmRtz:   ovf_to_inf = 1'b0;
      RmRdn:   ovf_to_inf = s1_sign_q;
      RmRup:   ovf_to_inf = ~s1_sign_q;
      default: ovf_to_inf = 1'b1;
    endcase

    res_bits  = {s1_sign_q, exp_fin[EXP_W-1:0], frac};
    res_flags = {s1_inv_q, 1'b0, 1'b0, s1_tiny_q & inexact, inexact};
    if (s1_nan_q) begin
      res_bits  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FW - 1){1'b0}}};
      res_flags = {s1_inv_q, 4'b0000};
    end else if (s1_inf_q) begin
      res_bits  = {s1_sign_q, {EXP_W{1'b1}}, {FW{1'b0}}};
      res_flags = {s1_inv_q, 4'b0000};
    end else if (s1_zero_q) begin
      res_bits  = {s1_sign_q, {(EXP_W + FW){1'b0}}};
      res_flags = {s1_inv_q, 4'b0000};
    end else if (ovf) begin
      res_bits  = ovf_to_inf ? {s1_sign_q, {EXP_W{1'b1}}, {FW{1'b0}}}
                             : {s1_sign_q, {(EXP_W - 1){1'b1}}, 1'b0, {FW{1'b1}}};
      res_flags = {s1_inv_q, 1'b0, 1'b1, 1'b0, 1'b1};
    end
  end

  logic [EXP_W+SIG_W-1:0] out_bits_q;
  logic [4:0]             out_flags_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q  <= 1'b0;
      out_bits_q  <= '0;
      out_flags_q <= '0;
    end else if (adv2) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_bits_q  <= res_bits;
        out_flags_q <= res_flags;
      end
    end
  end

  assign out_bits  = out_bits_q;
  assign out_flags = out_flags_q;

endmodule

// File: tb/tb_round_raw_fn_pipe.sv
module tb_round_raw_fn_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_is_nan = 1'b0, in_is_inf = 1'b0, in_is_zero = 1'b0;
  logic        in_sign = 1'b0;
  logic [9:0]  in_sexp = '0;
  logic [25:0] in_sig = '0;
  logic        in_invalid = 1'b0;
  logic [2:0]  in_rm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_bits;
  logic [4:0]  out_flags;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  round_raw_fn_pipe #(.EXP_W(8), .SIG_W(24)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_is_nan  (in_is_nan),
    .in_is_inf  (in_is_inf),
    .in_is_zero (in_is_zero),
    .in_sign    (in_sign),
    .in_sexp    (in_sexp),
    .in_sig     (in_sig),
    .in_invalid (in_invalid),
    .in_rm      (in_rm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_bits   (out_bits),
    .out_flags  (out_flags)
  );

  typedef struct {
    logic        sign;
    int          sexp;
    logic [23:0] sig;
    logic        r, s;
    logic [2:0]  rm;
    logic        nan, inf, zero, inv;
  } op_t;

  function automatic op_t mk_op(logic sign, int sexp, logic [23:0] sig, logic r, logic s,
                                logic [2:0] rm);
    op_t o;
    o.sign = sign; o.sexp = sexp; o.sig = sig; o.r = r; o.s = s; o.rm = rm;
    o.nan = 1'b0; o.inf = 1'b0; o.zero = 1'b0; o.inv = 1'b0;
    return o;
  endfunction

  // Reference: exact magnitude {sig, r} scaled into units of the target ulp,
  // rounded by comparing the remainder against half an ulp.
  function automatic logic [36:0] model(op_t o);
    int     e, k, eo, m;
    longint mag, den, q, rem;
    bit     above, tie, inexact, up, tiny, to_inf;
    logic [31:0] bits;
    logic [4:0]  flags;
    if (o.nan)  return {32'h7FC00000, o.inv, 4'b0};
    if (o.inf)  return {o.sign, 8'hFF, 23'd0, o.inv, 4'b0};
    if (o.zero) return {o.sign, 31'd0, o.inv, 4'b0};
    e    = o.sexp + 127;
    tiny = (e < 1);
    k    = tiny ? (1 - e) : 0;
    mag  = longint'({o.sig, o.r});
    if (k + 1 > 40) begin
      q = 0; above = 0; tie = 0; inexact = 1;
    end else begin
      den     = longint'(1) << (k + 1);
      q       = mag / den;
      rem     = mag % den;
      above   = (rem * 2 > den) || (rem * 2 == den && o.s);
      tie     = (rem * 2 == den) && !o.s;
      inexact = (rem != 0) || o.s;
    end
    m = (o.rm > 3'd4) ? 0 : int'(o.rm);
    case (m)
      0:       up = above || (tie && q[0]);
      1:       up = 0;
      2:       up = o.sign && inexact;
      3:       up = !o.sign && inexact;
      default: up = above || tie;
    endcase
    q = q + (up ? 1 : 0);
    if (!tiny) begin
      eo = e;
      if (q == 16777216) begin eo = e + 1; q = q / 2; end
    end else begin
      eo = (q >= 8388608) ? 1 : 0;
    end
    if (eo >= 255) begin
      to_inf = (m == 0) || (m == 4) || (m == 2 && o.sign) || (m == 3 && !o.sign);
      bits   = to_inf ? {o.sign, 31'h7F800000} : {o.sign, 31'h7F7FFFFF};
      flags  = {o.inv, 4'b0101};
    end else begin
      bits  = {o.sign, 8'(eo), 23'(q)};
      flags = {o.inv, 1'b0, 1'b0, tiny && inexact, inexact};
    end
    return {bits, flags};
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int  v;
    o = mk_op(1'($urandom), int'($urandom_range(0, 299)) - 165, {1'b1, 23'($urandom)},
              1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)));
    if ($urandom_range(0, 7) == 0) o.sig = 24'hFFFFFF;
    v = int'($urandom_range(0, 19));
    o.nan  = (v == 0);
    o.inf  = (v == 1) || (v == 3);
    o.zero = (v == 2) || (v == 3);
    o.inv  = ($urandom_range(0, 9) == 0);
    return o;
  endfunction

  task automatic drive_op(input op_t o);
    in_sign    = o.sign;
    in_sexp    = 10'(o.sexp);
    in_sig     = {o.sig, o.r, o.s};
    in_rm      = o.rm;
    in_is_nan  = o.nan;
    in_is_inf  = o.inf;
    in_is_zero = o.zero;
    in_invalid = o.inv;
  endtask

  // Sends one operand with out_ready high; lat counts cycles from accept to out_valid.
  task automatic run_single(input op_t o, output logic [31:0] bits, output logic [4:0] flags,
                            output int lat);
    int n = 0;
    @(negedge clk);
    drive_op(o);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    while (!in_ready && n < 20) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    #1;
    while (!out_valid && lat < 20) begin @(negedge clk); #1; lat++; end
    bits  = out_bits;
    flags = out_flags;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_bits !== 32'h0 || out_flags !== 5'h0 || in_ready !== 1'b1)
    begin
      failures++;
      $display("FAIL reset_state: valid=%b bits=%h flags=%h in_ready=%b required 0/0/0/1",
               out_valid, out_bits, out_flags, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_table(input string name, input op_t ops[4], input logic [31:0] eb[4],
                            input logic [4:0] ef[4], input int n);
    logic [31:0] b;
    logic [4:0]  f;
    int          lat;
    for (int i = 0; i < n; i++) begin
      run_single(ops[i], b, f, lat);
      checks++;
      if (b !== eb[i] || f !== ef[i] || lat != 2) begin
        failures++;
        $display("FAIL %s_%0d: bits=%h flags=%h lat=%0d required bits=%h flags=%h lat=2",
                 name, i, b, f, lat, eb[i], ef[i]);
      end
    end
  endtask

  task automatic test_basic();
    op_t ops[4]; logic [31:0] eb[4]; logic [4:0] ef[4];
    ops[0] = mk_op(0, 0, 24'h800000, 0, 0, 0); eb[0] = 32'h3F800000; ef[0] = 5'h00;
    ops[1] = ops[0]; ops[2] = ops[0]; ops[3] = ops[0];
    eb[1] = eb[0]; eb[2] = eb[0]; eb[3] = eb[0]; ef[1] = 0; ef[2] = 0; ef[3] = 0;
    test_table("basic", ops, eb, ef, 1);
  endtask

  task automatic test_rounding();
    op_t ops[4]; logic [31:0] eb[4]; logic [4:0] ef[4];
    ops[0] = mk_op(0, 0, 24'h800001, 1, 0, 0); eb[0] = 32'h3F800002; ef[0] = 5'h01;
    ops[1] = mk_op(0, 0, 24'h800000, 1, 0, 0); eb[1] = 32'h3F800000; ef[1] = 5'h01;
    ops[2] = mk_op(0, 0, 24'hFFFFFF, 1, 0, 0); eb[2] = 32'h40000000; ef[2] = 5'h01;
    ops[3] = mk_op(1, 0, 24'h800000, 0, 1, 4); eb[3] = 32'hBF800000; ef[3] = 5'h01;
    test_table("round", ops, eb, ef, 4);
  endtask

  task automatic test_overflow();
    op_t ops[4]; logic [31:0] eb[4]; logic [4:0] ef[4];
    ops[0] = mk_op(0, 128, 24'h800000, 0, 0, 0); eb[0] = 32'h7F800000; ef[0] = 5'h05;
    ops[1] = mk_op(0, 128, 24'h800000, 0, 0, 1); eb[1] = 32'h7F7FFFFF; ef[1] = 5'h05;
    ops[2] = mk_op(1, 128, 24'h800000, 0, 0, 3); eb[2] = 32'hFF7FFFFF; ef[2] = 5'h05;
    ops[3] = mk_op(0, 127, 24'hFFFFFF, 1, 0, 0); eb[3] = 32'h7F800000; ef[3] = 5'h05;
    test_table("ovf", ops, eb, ef, 4);
  endtask

  task automatic test_subnormal();
    op_t ops[4]; logic [31:0] eb[4]; logic [4:0] ef[4];
    ops[0] = mk_op(0, -127, 24'h800000, 0, 0, 0); eb[0] = 32'h00400000; ef[0] = 5'h00;
    ops[1] = mk_op(0, -150, 24'h800000, 0, 0, 0); eb[1] = 32'h00000000; ef[1] = 5'h03;
    ops[2] = mk_op(0, -150, 24'h800000, 0, 0, 3); eb[2] = 32'h00000001; ef[2] = 5'h03;
    ops[3] = mk_op(0, -127, 24'hFFFFFF, 1, 0, 0); eb[3] = 32'h00800000; ef[3] = 5'h03;
    test_table("subn", ops, eb, ef, 4);
  endtask

  task automatic test_specials();
    op_t ops[4]; logic [31:0] eb[4]; logic [4:0] ef[4];
    ops[0] = mk_op(1, 5, 24'h800000, 1, 1, 0); ops[0].nan = 1; ops[0].inf = 1; ops[0].inv = 1;
    eb[0] = 32'h7FC00000; ef[0] = 5'h10;
    ops[1] = mk_op(1, 0, 24'h800000, 1, 1, 0); ops[1].inf = 1;
    eb[1] = 32'hFF800000; ef[1] = 5'h00;
    ops[2] = mk_op(1, 0, 24'h800000, 0, 0, 0); ops[2].zero = 1;
    eb[2] = 32'h80000000; ef[2] = 5'h00;
    ops[3] = mk_op(0, 0, 24'h800000, 0, 0, 0); ops[3].inv = 1;
    eb[3] = 32'h3F800000; ef[3] = 5'h10;
    test_table("spec", ops, eb, ef, 4);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rb[$];
    int sent = 0, first = -1, last = -1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (sent < 8) begin
        drive_op(mk_op(0, sent, 24'h800000, 0, 0, 0));
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && in_ready) sent++;
      if (out_valid) begin
        rb.push_back(out_bits);
        if (first < 0) first = cyc;
        last = cyc;
      end
    end
    checks++;
    if (rb.size() != 8 || last - first != 7 || first != 2) begin
      failures++;
      $display("FAIL b2b_stream: results=%0d first=%0d last=%0d required 8 2 9",
               rb.size(), first, last);
    end
    for (int i = 0; i < rb.size(); i++) begin
      checks++;
      if (rb[i] !== 32'((127 + i) << 23)) begin
        failures++;
        $display("FAIL b2b_value_%0d: got %h required %h", i, rb[i], 32'((127 + i) << 23));
      end
    end
  endtask

  task automatic test_backpressure();
    op_t ops[3];
    logic [31:0] held = '0;
    int idx = 0, changes = 0;
    bit seen = 0;
    for (int i = 0; i < 3; i++) ops[i] = mk_op(0, i + 1, 24'h800000, 0, 0, 0);
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      drive_op(ops[idx]);
      in_valid = 1'b1;
      #1;
      if (out_valid) begin
        if (seen && out_bits !== held) changes++;
        if (!seen) held = out_bits;
        seen = 1;
      end
      if (in_ready) idx++;
    end
    checks++;
    if (idx != 2 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_accepts: accepted=%0d in_ready=%b required 2 0", idx, in_ready);
    end
    checks++;
    if (!seen || changes != 0 || held !== 32'h40000000) begin
      failures++;
      $display("FAIL bp_hold: seen=%0d changes=%0d held=%h required 1 0 40000000",
               seen, changes, held);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_bits !== 32'h40000000) begin
      failures++;
      $display("FAIL bp_drain0: valid=%b bits=%h required 1 40000000", out_valid, out_bits);
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_bits !== 32'h40800000) begin
      failures++;
      $display("FAIL bp_drain1: valid=%b bits=%h required 1 40800000", out_valid, out_bits);
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_empty: valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int extra = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive_op(mk_op(0, 3, 24'hC00000, 0, 0, 0));
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_full: valid=%b in_ready=%b required 1 0", out_valid, in_ready);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_bits !== 32'h0) begin
      failures++;
      $display("FAIL rst_async: valid=%b bits=%h required 0 0", out_valid, out_bits);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_ready: in_ready=%b required 1", in_ready);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      if (out_valid) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL rst_flush: stale results=%0d required 0", extra);
    end
  endtask

  task automatic test_random();
    localparam int N = 400;
    logic [36:0] q[$];
    logic [36:0] exp_v;
    op_t cur;
    bit  have = 0;
    int  sent = 0, cyc = 0;
    while ((sent < N || q.size() > 0) && cyc < 5000) begin
      @(negedge clk);
      if (!have && sent < N && $urandom_range(0, 9) < 7) begin
        cur  = rand_op();
        have = 1;
      end
      if (have) drive_op(cur);
      in_valid  = have;
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (in_valid && in_ready) begin
        q.push_back(model(cur));
        have = 0;
        sent++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL rand_extra: unexpected result %h/%h", out_bits, out_flags);
        end else begin
          exp_v = q.pop_front();
          if ({out_bits, out_flags} !== exp_v) begin
            failures++;
            $display("FAIL rand_result: bits=%h flags=%h required bits=%h flags=%h",
                     out_bits, out_flags, exp_v[36:5], exp_v[4:0]);
          end
        end
      end
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (sent != N || q.size() != 0) begin
      failures++;
      $display("FAIL rand_complete: sent=%0d pending=%0d required %0d 0", sent, q.size(), N);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_overflow();
    test_subnormal();
    test_specials();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
